wb2fta_bridge32: RTL and testbench
==================================

WB2FTA_BRIDGE32 -- requirements
Module: wb2fta_bridge32

Interface
REQ-001 SHALL have parameter TID_BASE, default 13'h0010, meaning upper tid bits [12:4] used for all issued requests.
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning cycles in WAIT before a read is errored.
REQ-003 SHALL have parameter PRI, default 4'd3, meaning priority placed on every request.
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: wb_cyc_i, wb_stb_i, wb_we_i input 1 each; wb_sel_i input 4; wb_adr_i input 32; wb_dat_i input 32 (classic WISHBONE target side).
REQ-006 SHALL have ports: wb_ack_o, wb_err_o, wb_stall_o output 1 each; wb_dat_o output 32.
REQ-007 SHALL have ports: req output fta_cmd_request32_t; resp input fta_cmd_response32_t; irq_o output 1 (pulse on IRQ message).

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, ACK, ERR; reset state IDLE.
REQ-009 IDLE: on wb_cyc_i & wb_stb_i SHALL capture we, sel, adr, dat and go to ISSUE next cycle.
REQ-010 ISSUE: req.cyc SHALL be 1 for exactly one cycle with we, sel, padr, dat from capture, pri=PRI, tid={TID_BASE[12:4], seq}, cti=CLASSIC.
REQ-011 seq SHALL be a 4-bit counter incremented after each ISSUE, wrapping 15->0.
REQ-012 Write: ISSUE -> ACK (posted, no FTA response expected); wb_ack_o asserts 2 cycles after stb sampled.
REQ-013 Read: ISSUE -> WAIT; WAIT exits on resp.ack & resp.err!=IRQ & resp.tid==issued tid.
REQ-014 On matching response with err==OKAY SHALL register resp.dat into wb_dat_o and go ACK; any other err SHALL go ERR.
REQ-015 Responses with non-matching tid SHALL be dropped silently in all states.
REQ-016 WAIT timeout counter SHALL load 0 on ISSUE, increment per WAIT cycle; reaching TIMEOUT SHALL go ERR.
REQ-017 ACK: wb_ack_o=1 one cycle, then IDLE; ERR: wb_err_o=1 one cycle, wb_dat_o=0, then IDLE.
REQ-018 wb_ack_o and wb_err_o SHALL never be 1 simultaneously, and only while wb_cyc_i & wb_stb_i.
REQ-019 If wb_cyc_i drops in ISSUE or WAIT SHALL abort to IDLE without ack; a later response for that tid SHALL be dropped.
REQ-020 wb_stall_o SHALL be 1 in every state except IDLE.
REQ-021 resp.ack & resp.err==IRQ SHALL pulse irq_o one cycle later, in any state, without affecting the state machine.
REQ-022 An IRQ message arriving the same cycle as a pending read SHALL not complete the read.
REQ-023 req SHALL be all-zero whenever not in ISSUE.

Reset
REQ-024 rst SHALL force state IDLE, seq=0, timeout=0, req all-zero, wb_ack_o=wb_err_o=irq_o=0, wb_dat_o=0, wb_stall_o=0.
REQ-025 rst mid-transaction SHALL discard the transaction; responses arriving after rst SHALL be dropped.

Structure
REQ-026 State enum wb2fta_state_t SHALL live in fta_bus_pkg; request/response types, CLASSIC, OKAY, IRQ come from fta_bus_pkg.
REQ-027 SHALL be a single module with no sub-modules; timeout counter and seq inline.

Verification
REQ-028 Write adr=32'h1000_0040 dat=32'hDEADBEEF sel=4'hF -> one req.cyc pulse with same fields, tid=13'h0010, wb_ack_o 2 cycles after stb.
REQ-029 Read adr=32'h2000_0000, resp tid=13'h0011 dat=32'h12345678 after 5 cycles -> wb_dat_o=32'h12345678, wb_ack_o one cycle later.
REQ-030 Read with no response, TIMEOUT=15 -> wb_err_o pulse after 15 WAIT cycles, wb_dat_o=0, next read accepted.
REQ-031 During WAIT inject resp err=IRQ tid=0, then stale tid 13'h001F -> irq_o pulse only, read still waits, completes on matching tid.
REQ-032 Issue 17 requests -> tid low nibble 0..15 then 0 (wrap).
REQ-033 Assert rst during WAIT, then deliver matching resp -> outputs zero, no wb_ack_o, state IDLE.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// Shared FTA command-bus types plus the WISHBONE-to-FTA bridge state encoding.
package fta_bus_pkg;

   typedef enum logic [2:0] {
      OKAY    = 3'd0,
      DECERR  = 3'd1,
      PROTERR = 3'd2,
      TGTERR  = 3'd3,
      IRQ     = 3'd7
   } fta_err_t;

   typedef enum logic [2:0] {
      CLASSIC = 3'd0,
      FIXED   = 3'd1,
      INCR    = 3'd2,
      EOB     = 3'd7
   } fta_cti_t;

   typedef struct packed {
      logic        cyc;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] padr;
      logic [31:0] dat;
      logic [3:0]  pri;
      logic [12:0] tid;
      fta_cti_t    cti;
   } fta_cmd_request32_t;

   typedef struct packed {
      logic        ack;
      fta_err_t    err;
      logic [12:0] tid;
      logic [31:0] dat;
   } fta_cmd_response32_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK,
      ERR
   } wb2fta_state_t;

endpackage

// File: rtl/wb2fta_bridge32.sv
// Classic WISHBONE target that forwards single accesses onto the FTA command bus.
// Writes are posted; reads wait for a tid-matched response or a timeout.
module wb2fta_bridge32
   import fta_bus_pkg::*;
#(
   parameter logic [12:0] TID_BASE = 13'h0010,
   parameter int          TIMEOUT  = 1023,
   parameter logic [3:0]  PRI      = 4'd3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [3:0]          wb_sel_i,
   input  logic [31:0]         wb_adr_i,
   input  logic [31:0]         wb_dat_i,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic                wb_stall_o,
   output logic [31:0]         wb_dat_o,
   output fta_cmd_request32_t  req,
   input  fta_cmd_response32_t resp,
   output logic                irq_o
);

   localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   wb2fta_state_t state, state_d;
   logic [3:0]    seq, tid_lo;
   logic [TW-1:0] tmo;
   logic          cap_we;
   logic [3:0]    cap_sel;
   logic [31:0]   cap_adr, cap_dat, dat_q;
   logic          irq_q;
   logic          wb_active, rsp_hit;

   assign wb_active = wb_cyc_i & wb_stb_i;
   // IRQ messages never complete a read, even when their tid happens to match.
   assign rsp_hit   = resp.ack && (resp.err != IRQ) && (resp.tid == {TID_BASE[12:4], tid_lo});

   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (wb_active) state_d = ISSUE;
         ISSUE: begin
            if (!wb_cyc_i)   state_d = IDLE;
            else if (cap_we) state_d = ACK;
            else             state_d = WAIT;
         end
         WAIT: begin
            if (!wb_cyc_i)            state_d = IDLE;
            else if (rsp_hit)         state_d = (resp.err == OKAY) ? ACK : ERR;
            else if (tmo == TMO_LAST) state_d = ERR;
         end
         ACK, ERR: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         seq     <= '0;
         tid_lo  <= '0;
         tmo     <= '0;
         cap_we  <= 1'b0;
         cap_sel <= '0;
         cap_adr <= '0;
         cap_dat <= '0;
         dat_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state <= state_d;
         irq_q <= resp.ack && (resp.err == IRQ);
         if (state == IDLE && wb_active) begin
            cap_we  <= wb_we_i;
            cap_sel <= wb_sel_i;
            cap_adr <= wb_adr_i;
            cap_dat <= wb_dat_i;
         end
         if (state == ISSUE) begin
            seq    <= seq + 4'd1;
            tid_lo <= seq;
            tmo    <= '0;
         end else if (state == WAIT) begin
            tmo <= tmo + 1'b1;
         end
         if (state == WAIT && state_d == ACK) dat_q <= resp.dat;
         else if (state_d == ERR)             dat_q <= '0;
      end
   end

   always_comb begin
      req = '0;
      if (!rst && state == ISSUE) begin
         req.cyc  = 1'b1;
         req.we   = cap_we;
         req.sel  = cap_sel;
         req.padr = cap_adr;
         req.dat  = cap_dat;
         req.pri  = PRI;
         req.tid  = {TID_BASE[12:4], seq};
         req.cti  = CLASSIC;
      end
   end

   assign wb_ack_o   = !rst && (state == ACK) && wb_active;
   assign wb_err_o   = !rst && (state == ERR) && wb_active;
   assign wb_stall_o = !rst && (state != IDLE);
   assign wb_dat_o   = dat_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb2fta_bridge32.sv
// Directed bench for wb2fta_bridge32: vector table plus hand-built IRQ, abort,
// reset and tid-wrap sequences.
module tb_wb2fta_bridge32;
   import fta_bus_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [3:0]          wb_sel = '0;
   logic [31:0]         wb_adr = '0, wb_dat_w = '0;
   logic                wb_ack, wb_err, wb_stall, irq;
   logic [31:0]         wb_dat_r;
   fta_cmd_request32_t  req;
   fta_cmd_response32_t resp = '0;

   always #5 clk = ~clk;

   wb2fta_bridge32 #(.TID_BASE(13'h0010), .TIMEOUT(15), .PRI(4'd3)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
      .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
      .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_stall_o(wb_stall), .wb_dat_o(wb_dat_r),
      .req(req), .resp(resp), .irq_o(irq)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus-protocol invariants sampled every cycle.
   always @(negedge clk) begin
      chk("ack_err_excl", 64'(wb_ack & wb_err), 64'd0);
      if (!req.cyc) chk("req_idle_zero", 64'(req != '0), 64'd0);
      if (!(wb_cyc && wb_stb)) chk("ack_gated", 64'(wb_ack | wb_err), 64'd0);
   end

   typedef struct {
      int          at;
      logic [12:0] tid;
      fta_err_t    err;
      logic [31:0] dat;
   } rsp_ev_t;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      rsp_ev_t     rsp;
      int          exp_ack;
      int          exp_err;
      logic [12:0] exp_tid;
      logic [31:0] exp_dat;
   } vec_t;

   int                 r_ack, r_err, r_reqs, r_irqs, r_irq_first;
   logic               r_stall1;
   fta_cmd_request32_t r_req;
   logic [31:0]        r_dat;

   // Cycle index i: 0 = stb presented (IDLE), 1 = ISSUE, 2.. = WAIT/ACK/ERR.
   task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input rsp_ev_t ev [4]);
      r_ack = -1; r_err = -1; r_reqs = 0; r_irqs = 0; r_irq_first = -1;
      r_stall1 = 1'b0; r_req = '0; r_dat = '0;
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_w = dat;
      for (int i = 0; i < 40; i++) begin
         resp = '0;
         for (int k = 0; k < 4; k++)
            if (ev[k].at == i) begin
               resp.ack = 1'b1; resp.err = ev[k].err; resp.tid = ev[k].tid; resp.dat = ev[k].dat;
            end
         @(negedge clk);
         if (i == 1) r_stall1 = wb_stall;
         if (req.cyc) begin r_reqs++; r_req = req; end
         if (irq) begin r_irqs++; if (r_irq_first < 0) r_irq_first = i; end
         if (wb_ack && r_ack < 0) begin r_ack = i; r_dat = wb_dat_r; end
         if (wb_err && r_err < 0) begin r_err = i; r_dat = wb_dat_r; end
         @(posedge clk); #1;
         if (r_ack >= 0 || r_err >= 0) break;
      end
      resp = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   vec_t    vecs [7];
   rsp_ev_t evs [4];
   int      seen;

   initial begin
      vecs[0] = '{1'b1, 4'hF, 32'h1000_0040, 32'hDEAD_BEEF, '{-1, 13'h0000, OKAY, 32'h0},
                  2, -1, 13'h0010, 32'h0};
      vecs[1] = '{1'b0, 4'hF, 32'h2000_0000, 32'h0, '{6, 13'h0011, OKAY, 32'h1234_5678},
                  7, -1, 13'h0011, 32'h1234_5678};
      vecs[2] = '{1'b0, 4'hF, 32'h2000_0100, 32'h0, '{-1, 13'h0000, OKAY, 32'h0},
                  -1, 17, 13'h0012, 32'h0};
      vecs[3] = '{1'b0, 4'h3, 32'h3000_0004, 32'h0, '{3, 13'h0013, DECERR, 32'h5555_5555},
                  -1, 4, 13'h0013, 32'h0};
      vecs[4] = '{1'b1, 4'h1, 32'h4000_0008, 32'h0000_00A5, '{-1, 13'h0000, OKAY, 32'h0},
                  2, -1, 13'h0014, 32'h0};
      vecs[5] = '{1'b0, 4'hC, 32'h5000_0000, 32'h0, '{2, 13'h0015, OKAY, 32'hCAFE_F00D},
                  3, -1, 13'h0015, 32'hCAFE_F00D};
      vecs[6] = '{1'b0, 4'hF, 32'h6000_0010, 32'h0, '{3, 13'h001F, OKAY, 32'h1111_1111},
                  -1, 17, 13'h0016, 32'h0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", 64'(wb_stall), 64'd0);
      chk("rst_ack",   64'(wb_ack),   64'd0);
      chk("rst_err",   64'(wb_err),   64'd0);
      chk("rst_irq",   64'(irq),      64'd0);
      chk("rst_dat",   64'(wb_dat_r), 64'd0);
      chk("rst_req",   64'(req != '0), 64'd0);

      for (int n = 0; n < 7; n++) begin
         for (int k = 0; k < 4; k++) evs[k].at = -1;
         evs[0] = vecs[n].rsp;
         xfer(vecs[n].we, vecs[n].sel, vecs[n].adr, vecs[n].dat, evs);
         chk("ack_cycle",  64'(r_ack),    64'(vecs[n].exp_ack));
         chk("err_cycle",  64'(r_err),    64'(vecs[n].exp_err));
         chk("req_pulses", 64'(r_reqs),   64'd1);
         chk("stall_busy", 64'(r_stall1), 64'd1);
         chk("req_we",     64'(r_req.we),   64'(vecs[n].we));
         chk("req_sel",    64'(r_req.sel),  64'(vecs[n].sel));
         chk("req_padr",   64'(r_req.padr), 64'(vecs[n].adr));
         chk("req_dat",    64'(r_req.dat),  64'(vecs[n].dat));
         chk("req_pri",    64'(r_req.pri),  64'd3);
         chk("req_tid",    64'(r_req.tid),  64'(vecs[n].exp_tid));
         chk("req_cti",    64'(r_req.cti),  64'(CLASSIC));
         if (!vecs[n].we) chk("rd_dat", 64'(r_dat), 64'(vecs[n].exp_dat));
      end

      // IRQ and stale responses during WAIT; matching-tid IRQ must not complete the read.
      evs[0] = '{3, 13'h0000, IRQ,  32'h0};
      evs[1] = '{5, 13'h001F, OKAY, 32'h9999_9999};
      evs[2] = '{7, 13'h0017, IRQ,  32'h0};
      evs[3] = '{9, 13'h0017, OKAY, 32'h0BAD_F00D};
      xfer(1'b0, 4'hF, 32'h2000_0000, 32'h0, evs);
      chk("irq_count", 64'(r_irqs),      64'd2);
      chk("irq_first", 64'(r_irq_first), 64'd4);
      chk("irq_rd_ack", 64'(r_ack),      64'd10);
      chk("irq_rd_dat", 64'(r_dat),      64'h0BAD_F00D);

      // Master abandons the read in WAIT; the late response must be ignored.
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h7000_0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_wait_stall", 64'(wb_stall), 64'd1);
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      resp = '0; resp.ack = 1'b1; resp.err = OKAY; resp.tid = 13'h0018; resp.dat = 32'h7777_7777;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wb_ack || wb_err || wb_stall) seen++;
         @(posedge clk); #1;
         resp = '0;
      end
      chk("abort_no_ack", 64'(seen), 64'd0);
      for (int k = 0; k < 4; k++) evs[k].at = -1;
      xfer(1'b1, 4'hF, 32'h0000_0100, 32'h0102_0304, evs);
      chk("abort_next_tid", 64'(r_req.tid), 64'h0019);
      chk("abort_next_ack", 64'(r_ack),     64'd2);

      // Reset lands while a read is waiting; its response arrives afterwards.
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h8000_0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      resp = '0; resp.ack = 1'b1; resp.err = OKAY; resp.tid = 13'h001A; resp.dat = 32'hABCD_0123;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wb_ack || wb_err || wb_stall || irq || wb_dat_r != 32'h0 || req != '0) seen++;
         @(posedge clk); #1;
         resp = '0;
      end
      chk("rst_wait_quiet", 64'(seen), 64'd0);

      // Sequence number restarts at 0 after reset and wraps 15 -> 0.
      for (int n = 0; n < 17; n++) begin
         logic [3:0] nib;
         nib = 4'(n);
         for (int k = 0; k < 4; k++) evs[k].at = -1;
         xfer(1'b1, 4'hF, 32'h0000_0200 + 32'(n), 32'(n), evs);
         chk("wrap_tid", 64'(r_req.tid), 64'({9'h001, nib}));
         chk("wrap_ack", 64'(r_ack),     64'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
